// File: rtl/dma_ctrl.sv
// dma_ctrl: single-channel memory-to-memory DMA that stalls the CPU via RDY and masters the bus.
// SRC/DST/LEN are live counters; each byte is a READ, RD_LAT-1 WAITs and a WRITE.
module dma_ctrl #(
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cs_i,
  input  logic        we_i,
  input  logic [2:0]  rs_i,
  input  logic [7:0]  din_i,
  output logic [7:0]  dout_o,
  output logic        irq_o,
  output logic        cpu_rdy_o,
  output logic        bus_req_o,
  output logic [15:0] m_addr_o,
  output logic        m_we_o,
  output logic [7:0]  m_dout_o,
  input  logic [7:0]  m_din_i
);
  typedef enum logic [2:0] {IDLE, GRANT, READ, WAIT, WRITE, DONE} state_t;
  state_t state_q, state_d;
  logic [15:0] src_q, src_d, dst_q, dst_d, len_q, len_d;
  logic [7:0] dout_q, dout_d, rdata;
  logic [1:0] wcnt_q, wcnt_d;
  logic ien_q, ien_d, done_q, done_d, irq_q, irq_d;
  logic busy, acc, wr, rd, ctrl_wr, start;
  assign busy = state_q inside {GRANT, READ, WAIT, WRITE};
  assign acc = state_q == IDLE || state_q == DONE;
  assign wr = cs_i & we_i & acc;
  assign rd = cs_i & ~we_i & acc;
  assign ctrl_wr = wr & (rs_i == 3'd6);
  assign start = ctrl_wr & din_i[0];
  assign cpu_rdy_o = ~busy;
  assign bus_req_o = state_q inside {READ, WAIT, WRITE};
  assign m_we_o = state_q == WRITE;
  assign m_addr_o = m_we_o ? dst_q : bus_req_o ? src_q : 16'h0000;
  // Write data comes straight from the read mux so it is valid alongside m_we.
  assign m_dout_o = m_we_o ? m_din_i : 8'h00;
  assign dout_o = dout_q;
  assign irq_o = irq_q;
  always_comb begin
    case (rs_i)
      3'd0: rdata = src_q[7:0];
      3'd1: rdata = src_q[15:8];
      3'd2: rdata = dst_q[7:0];
      3'd3: rdata = dst_q[15:8];
      3'd4: rdata = len_q[7:0];
      3'd5: rdata = len_q[15:8];
      3'd6: rdata = {6'b0, ien_q, 1'b0};
      default: rdata = {6'b0, done_q, busy};
    endcase
  end
  always_comb begin
    state_d = state_q;
    src_d = src_q;
    dst_d = dst_q;
    len_d = len_q;
    wcnt_d = wcnt_q;
    ien_d = ctrl_wr ? din_i[1] : ien_q;
    dout_d = rd ? rdata : dout_q;
    irq_d = done_q & ien_q;
    // A STATUS read only clears what it returned, so a flag set this cycle survives.
    done_d = (done_q & ~ctrl_wr & ~(rd & rs_i == 3'd7)) | (start & len_q == 16'h0000) |
             (state_q == DONE & ~ctrl_wr);
    if (wr) begin
      case (rs_i)
        3'd0: src_d[7:0] = din_i;
        3'd1: src_d[15:8] = din_i;
        3'd2: dst_d[7:0] = din_i;
        3'd3: dst_d[15:8] = din_i;
        3'd4: len_d[7:0] = din_i;
        3'd5: len_d[15:8] = din_i;
        default: ;
      endcase
    end
    case (state_q)
      IDLE, DONE: state_d = (start && len_q != 16'h0000) ? GRANT : IDLE;
      GRANT: state_d = READ;
      READ: begin
        state_d = RD_LAT == 1 ? WRITE : WAIT;
        wcnt_d = 2'(RD_LAT - 2);
      end
      WAIT: begin
        state_d = wcnt_q == 2'd0 ? WRITE : WAIT;
        wcnt_d = wcnt_q - 2'd1;
      end
      WRITE: begin
        src_d = src_q + 16'd1;
        dst_d = dst_q + 16'd1;
        len_d = len_q - 16'd1;
        state_d = len_q == 16'd1 ? DONE : READ;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      src_q <= 16'h0000;
      dst_q <= 16'h0000;
      len_q <= 16'h0000;
      wcnt_q <= 2'd0;
      ien_q <= 1'b0;
      done_q <= 1'b0;
      irq_q <= 1'b0;
      dout_q <= 8'h00;
    end else begin
      state_q <= state_d;
      src_q <= src_d;
      dst_q <= dst_d;
      len_q <= len_d;
      wcnt_q <= wcnt_d;
      ien_q <= ien_d;
      done_q <= done_d;
      irq_q <= irq_d;
      dout_q <= dout_d;
    end
  end
endmodule

// File: tb/tb_dma_ctrl.sv
// tb_dma_ctrl: three dma_ctrl instances (RD_LAT 1, 2, 4) sharing one memory model.
// Expected bus writes are queued per transfer and popped as m_we pulses appear.
module tb_dma_ctrl;
  logic clk = 0, rst_n = 0, cs = 0, we = 0;
  logic [2:0] rs = 0;
  logic [7:0] din = 0;
  int sel = 0;
  logic [7:0] dout [3], m_dout [3], m_din [3];
  logic [15:0] maddr [3];
  logic irq [3], rdy [3], breq [3], mwe [3];
  logic [7:0] pipe [3][4];
  logic [7:0] mem [int];
  logic [23:0] sb [$];
  logic [23:0] exp_w;
  logic breq_prev = 0;
  int n_tests = 0, n_fail = 0, cyc = 0, rdy_low = 0, breq_cnt = 0, we_cnt = 0, rd_cyc = 0, we_cyc = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    dma_ctrl #(.RD_LAT(g == 0 ? 1 : (g == 1 ? 2 : 4))) u_dut (
      .clk(clk), .rst_n(rst_n), .cs_i(cs && sel == g), .we_i(we), .rs_i(rs), .din_i(din),
      .dout_o(dout[g]), .irq_o(irq[g]), .cpu_rdy_o(rdy[g]), .bus_req_o(breq[g]),
      .m_addr_o(maddr[g]), .m_we_o(mwe[g]), .m_dout_o(m_dout[g]), .m_din_i(m_din[g]));
    assign m_din[g] = pipe[g][(g == 0 ? 1 : (g == 1 ? 2 : 4)) - 1];
  end
  function automatic logic [7:0] init_b(input logic [15:0] a);
    return a == 16'hF000 ? 8'h11 : a == 16'hF001 ? 8'h22 : a == 16'hF002 ? 8'h33 :
           a == 16'hF003 ? 8'h44 : a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction
  function automatic logic [7:0] rdm(input logic [15:0] a);
    return mem.exists(int'(a)) ? mem[int'(a)] : init_b(a);
  endfunction
  always @(posedge clk) begin
    for (int g = 0; g < 3; g++) begin
      pipe[g][0] <= rdm(maddr[g]);
      for (int k = 1; k < 4; k++) pipe[g][k] <= pipe[g][k-1];
    end
  end
  always @(negedge clk) begin
    cyc++;
    if (!rdy[sel]) rdy_low++;
    if (breq[sel]) breq_cnt++;
    if (breq[sel] && !breq_prev && rd_cyc == 0) rd_cyc = cyc;
    breq_prev = breq[sel];
    if (mwe[sel]) begin
      we_cnt++;
      we_cyc = cyc;
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_empty: write %h<=%h, required no write", maddr[sel], m_dout[sel]);
      end else begin
        exp_w = sb.pop_front();
        if ({maddr[sel], m_dout[sel]} !== exp_w) begin
          n_fail++;
          $display("FAIL sb_write: got %h<=%h, want %h<=%h", maddr[sel], m_dout[sel], exp_w[23:8], exp_w[7:0]);
        end
      end
      n_tests++;
      if (m_dout[sel] !== m_din[sel]) begin
        n_fail++;
        $display("FAIL wdata_path: m_dout %h, want m_din %h", m_dout[sel], m_din[sel]);
      end
      mem[int'(maddr[sel])] = m_dout[sel];
    end
  end
  task automatic wr(input logic [2:0] r, input logic [7:0] d);
    cs = 1; we = 1; rs = r; din = d;
    @(negedge clk);
    cs = 0; we = 0;
  endtask
  task automatic rd(input logic [2:0] r, output logic [7:0] d);
    cs = 1; we = 0; rs = r;
    @(negedge clk);
    cs = 0;
    d = dout[sel];
  endtask
  task automatic rd16(input logic [2:0] r, output logic [15:0] v);
    logic [7:0] lo, hi;
    rd(r, lo);
    rd(r + 3'd1, hi);
    v = {hi, lo};
  endtask
  task automatic setup(input logic [15:0] s, input logic [15:0] d, input logic [15:0] n);
    wr(0, s[7:0]); wr(1, s[15:8]); wr(2, d[7:0]); wr(3, d[15:8]); wr(4, n[7:0]); wr(5, n[15:8]);
  endtask
  task automatic push(input logic [15:0] s, input logic [15:0] d, input int n);
    for (int i = 0; i < n; i++) sb.push_back({d + 16'(i), init_b(s + 16'(i))});
  endtask
  task automatic clr;
    rdy_low = 0; breq_cnt = 0; we_cnt = 0; rd_cyc = 0;
  endtask
  task automatic wait_done;
    int k = 0;
    while (!rdy[sel] && k < 500) begin
      @(negedge clk);
      k++;
    end
    n_tests++;
    if (k >= 500) begin n_fail++; $display("FAIL done_timeout: cpu_rdy %b after %0d cycles, want 1", rdy[sel], k); end
    repeat (2) @(negedge clk);
  endtask
  task automatic test_reset;
    logic [7:0] v;
    sel = 0;
    repeat (3) @(negedge clk);
    n_tests++; if ({dout[0], m_dout[0]} !== 16'h0) begin n_fail++; $display("FAIL rst_data: got %h, want 0000", {dout[0], m_dout[0]}); end
    n_tests++; if ({irq[0], rdy[0], breq[0], mwe[0]} !== 4'b0100) begin n_fail++; $display("FAIL rst_ctl: got %b, want 0100", {irq[0], rdy[0], breq[0], mwe[0]}); end
    n_tests++; if (maddr[0] !== 16'h0) begin n_fail++; $display("FAIL rst_addr: got %h, want 0000", maddr[0]); end
    rst_n = 1;
    @(negedge clk);
    rd(7, v);
    n_tests++; if (v !== 8'h00) begin n_fail++; $display("FAIL rst_status: got %h, want 00", v); end
  endtask
  task automatic test_copy;
    logic [15:0] v;
    logic [7:0] b;
    sel = 0;
    setup(16'hF000, 16'h0100, 16'd4);
    push(16'hF000, 16'h0100, 4);
    clr;
    wr(6, 8'h01);
    wait_done;
    n_tests++; if (rdy_low !== 9) begin n_fail++; $display("FAIL copy_stall: got %0d, want 9", rdy_low); end
    n_tests++; if (we_cnt !== 4 || sb.size() !== 0) begin n_fail++; $display("FAIL copy_writes: got %0d left %0d, want 4 left 0", we_cnt, sb.size()); end
    n_tests++; if ({rdm(16'h0100), rdm(16'h0101), rdm(16'h0102), rdm(16'h0103)} !== 32'h11223344) begin n_fail++; $display("FAIL copy_ram: got %h%h%h%h, want 11223344", rdm(16'h0100), rdm(16'h0101), rdm(16'h0102), rdm(16'h0103)); end
    rd16(0, v); n_tests++; if (v !== 16'hF004) begin n_fail++; $display("FAIL copy_src: got %h, want F004", v); end
    rd16(2, v); n_tests++; if (v !== 16'h0104) begin n_fail++; $display("FAIL copy_dst: got %h, want 0104", v); end
    rd16(4, v); n_tests++; if (v !== 16'h0000) begin n_fail++; $display("FAIL copy_len: got %h, want 0000", v); end
    rd(7, b); n_tests++; if (b !== 8'h02) begin n_fail++; $display("FAIL copy_status1: got %h, want 02", b); end
    rd(7, b); n_tests++; if (b !== 8'h00) begin n_fail++; $display("FAIL copy_status2: got %h, want 00", b); end
    n_tests++; if (irq[0] !== 1'b0) begin n_fail++; $display("FAIL copy_irq: got %b, want 0", irq[0]); end
  endtask
  task automatic test_len0;
    logic [7:0] b;
    sel = 0;
    wr(4, 8'h00); wr(5, 8'h00);
    clr;
    wr(6, 8'h03);
    n_tests++; if (irq[0] !== 1'b0) begin n_fail++; $display("FAIL len0_irq_early: got %b, want 0", irq[0]); end
    @(negedge clk);
    n_tests++; if (irq[0] !== 1'b1) begin n_fail++; $display("FAIL len0_irq: got %b, want 1", irq[0]); end
    n_tests++; if (breq_cnt !== 0 || we_cnt !== 0 || rdy_low !== 0) begin n_fail++; $display("FAIL len0_bus: got breq %0d we %0d stall %0d, want 0 0 0", breq_cnt, we_cnt, rdy_low); end
    wr(6, 8'h02);
    @(negedge clk);
    n_tests++; if (irq[0] !== 1'b0) begin n_fail++; $display("FAIL len0_irq_clear: got %b, want 0", irq[0]); end
    rd(7, b); n_tests++; if (b !== 8'h00) begin n_fail++; $display("FAIL len0_status: got %h, want 00", b); end
  endtask
  task automatic test_wrap;
    logic [15:0] v;
    sel = 1;
    setup(16'h0FFE, 16'hFFFF, 16'd3);
    push(16'h0FFE, 16'hFFFF, 3);
    clr;
    wr(6, 8'h01);
    wait_done;
    n_tests++; if (rdy_low !== 10) begin n_fail++; $display("FAIL wrap_stall: got %0d, want 10", rdy_low); end
    n_tests++; if (we_cnt !== 3 || sb.size() !== 0) begin n_fail++; $display("FAIL wrap_writes: got %0d left %0d, want 3 left 0", we_cnt, sb.size()); end
    rd16(2, v); n_tests++; if (v !== 16'h0002) begin n_fail++; $display("FAIL wrap_dst: got %h, want 0002", v); end
    rd16(0, v); n_tests++; if (v !== 16'h1001) begin n_fail++; $display("FAIL wrap_src: got %h, want 1001", v); end
  endtask
  task automatic test_reset_mid;
    logic [7:0] b;
    logic [7:0] ex;
    int k = 0;
    sel = 0;
    setup(16'h2000, 16'h3000, 16'd8);
    push(16'h2000, 16'h3000, 8);
    clr;
    wr(6, 8'h01);
    while (we_cnt < 2 && k < 200) begin
      @(negedge clk);
      k++;
    end
    n_tests++; if (k >= 200) begin n_fail++; $display("FAIL mid_timeout: got %0d writes, want 2", we_cnt); end
    @(posedge clk);
    #1 rst_n = 0;
    #1;
    n_tests++; if ({irq[0], rdy[0], breq[0], mwe[0]} !== 4'b0100) begin n_fail++; $display("FAIL mid_ctl: got %b, want 0100", {irq[0], rdy[0], breq[0], mwe[0]}); end
    n_tests++; if ({maddr[0], m_dout[0], dout[0]} !== 32'h0) begin n_fail++; $display("FAIL mid_bus: got %h, want 00000000", {maddr[0], m_dout[0], dout[0]}); end
    @(negedge clk);
    rst_n = 1;
    n_tests++; if (sb.size() !== 6) begin n_fail++; $display("FAIL mid_left: got %0d, want 6", sb.size()); end
    sb.delete();
    for (int i = 0; i < 8; i++) ex[i] = mem.exists(32'h3000 + i);
    n_tests++; if (ex !== 8'b0000_0011) begin n_fail++; $display("FAIL mid_dst_touched: got %b, want 00000011", ex); end
    rd(0, b); n_tests++; if (b !== 8'h00) begin n_fail++; $display("FAIL mid_src: got %h, want 00", b); end
    rd(4, b); n_tests++; if (b !== 8'h00) begin n_fail++; $display("FAIL mid_len: got %h, want 00", b); end
    rd(7, b); n_tests++; if (b !== 8'h00) begin n_fail++; $display("FAIL mid_status: got %h, want 00", b); end
  endtask
  task automatic test_ignore;
    logic [15:0] v;
    logic [7:0] b;
    sel = 0;
    setup(16'h4000, 16'h5000, 16'd3);
    push(16'h4000, 16'h5000, 3);
    clr;
    wr(6, 8'h01);
    wr(0, 8'h77); wr(1, 8'h12); wr(4, 8'h09); wr(6, 8'h02);
    wait_done;
    n_tests++; if (rdy_low !== 7) begin n_fail++; $display("FAIL ign_stall: got %0d, want 7", rdy_low); end
    n_tests++; if (we_cnt !== 3 || sb.size() !== 0) begin n_fail++; $display("FAIL ign_writes: got %0d left %0d, want 3 left 0", we_cnt, sb.size()); end
    rd16(0, v); n_tests++; if (v !== 16'h4003) begin n_fail++; $display("FAIL ign_src: got %h, want 4003", v); end
    rd16(4, v); n_tests++; if (v !== 16'h0000) begin n_fail++; $display("FAIL ign_len: got %h, want 0000", v); end
    rd(6, b); n_tests++; if (b !== 8'h00) begin n_fail++; $display("FAIL ign_ctrl: got %h, want 00", b); end
    rd(7, b); n_tests++; if (b !== 8'h02) begin n_fail++; $display("FAIL ign_status: got %h, want 02", b); end
  endtask
  task automatic test_lat4;
    sel = 2;
    setup(16'h6000, 16'h7000, 16'd1);
    push(16'h6000, 16'h7000, 1);
    clr;
    wr(6, 8'h01);
    wait_done;
    n_tests++; if (we_cnt !== 1 || sb.size() !== 0) begin n_fail++; $display("FAIL lat4_writes: got %0d left %0d, want 1 left 0", we_cnt, sb.size()); end
    n_tests++; if (we_cyc - rd_cyc !== 4) begin n_fail++; $display("FAIL lat4_delay: got %0d, want 4", we_cyc - rd_cyc); end
    n_tests++; if (rdy_low !== 6) begin n_fail++; $display("FAIL lat4_stall: got %0d, want 6", rdy_low); end
  endtask
  initial begin
    test_reset;
    test_copy;
    test_len0;
    test_wrap;
    test_reset_mid;
    test_ignore;
    test_lat4;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1);
  end
endmodule

// File: doc/dma_ctrl.md
# dma_ctrl

Single-channel memory-to-memory DMA engine for the 6502 SoC. It sits on the CPU bus as a register-mapped peripheral at an unused 4 KB page. When started, it stalls the CPU via RDY and becomes bus master for the top-level address/data mux. It then copies LEN bytes from SRC to DST, one byte at a time through the same synchronous memories the CPU uses, and raises a done flag and optional IRQ on completion.

## Interface
- RD_LAT, 1: cycles from `m_addr` valid to `m_din` valid; legal range 1..4. Matches the registered RAM/ROM/IO read path plus the registered data-mux select.
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- cs  in  1  register chip select from page decode
- we  in  1  CPU write enable
- rs  in  3  register select (CPU address [2:0])
- din  in  8  CPU write data
- dout  out  8  register read data, registered (valid the cycle after address)
- irq  out  1  interrupt request, active-high
- cpu_rdy  out  1  CPU RDY; 0 stalls the CPU
- bus_req  out  1  1 = top level routes `m_addr`/`m_we`/`m_dout` to the memory bus instead of the CPU
- m_addr  out  16  master address
- m_we  out  1  master write strobe
- m_dout  out  8  master write data
- m_din  in  8  master read data from top-level data mux

## Operation
- Registers (cs=1): 0 SRC_LO, 1 SRC_HI, 2 DST_LO, 3 DST_HI, 4 LEN_LO, 5 LEN_HI, 6 CTRL, 7 STATUS.
- CTRL: bit0 START (write-only strobe, reads 0), bit1 IEN.
- STATUS: bit0 BUSY, bit1 DONE; other bits read 0.
- Writes to regs 0–6 are accepted in IDLE and DONE only; ignored otherwise.
- Writing CTRL with START=1 clears DONE.
  - LEN=0: DONE is set the next cycle; no bus cycles occur.
  - LEN≠0: the FSM enters GRANT.
- Writing CTRL with START=0 updates IEN and clears DONE.
- Reading STATUS (cs & !we & rs=7) clears DONE after the read data is captured.
- SRC, DST and LEN are live counters:
  - after each byte, SRC+1 and DST+1 (16-bit, wrap FFFF→0000) and LEN−1;
  - at completion, SRC/DST point one past the last byte and LEN=0.
- FSM:
  - IDLE → GRANT on START with LEN≠0.
  - GRANT (1 cycle; lets the CPU's START write cycle retire) → READ.
  - READ: drive `m_addr`=SRC, m_we=0 → WAIT.
  - WAIT: RD_LAT−1 cycles; when RD_LAT=1 this state is skipped and READ goes directly to WRITE.
  - WRITE: capture `m_din` into `m_dout`, drive `m_addr`=DST, m_we=1, update counters. Then go to READ if the new LEN≠0, else DONE.
  - DONE (1 cycle): set DONE flag → IDLE.
- Outputs by state:
  - cpu_rdy=0 in GRANT, READ, WAIT, WRITE; 1 otherwise.
  - bus_req=1 in READ, WAIT, WRITE only.
  - BUSY=1 whenever cpu_rdy=0.
- irq = DONE & IEN, registered.
- `m_dout` in WRITE carries the byte read by the preceding READ. The write-data path is combinational from `m_din` into the write cycle, so write data is valid in the same cycle as m_we.
- Overlapping ranges are copied ascending with no correction; a forward overlap replicates bytes.

## Timing
- Reset values: dout=00, irq=0, cpu_rdy=1, bus_req=0, m_addr=0000, m_we=0, m_dout=00. All registers are 0; FSM is in IDLE.
- START is written in cycle T. GRANT occurs in T+1 and the first READ in T+2.
- Each byte costs RD_LAT+1 cycles.
- A transfer of N≥1 bytes holds cpu_rdy low for exactly 1+N·(RD_LAT+1) cycles. DONE follows; cpu_rdy=1 in the DONE cycle.
- irq rises one cycle after DONE is set and falls the cycle after DONE is cleared.
- m_we is high only in WRITE, for exactly one cycle per byte.
- Reset asserted mid-transfer: immediate return to reset values, including bus_req=0 and cpu_rdy=1. Bytes already written stay written.
- cs/we during GRANT..WRITE are ignored, since the CPU is stalled.

## Test plan
- RD_LAT=1; SRC=F000, DST=0100, LEN=4; ROM F000..F003=11,22,33,44; write CTRL=01 → RAM 0100..0103=11,22,33,44; cpu_rdy low exactly 9 cycles; final SRC=F004, DST=0104, LEN=0000; STATUS reads 02, then 00.
- LEN=0000, CTRL=03 → no m_we pulse, bus_req never high, DONE set next cycle, irq=1 one cycle later; CTRL write 02 → irq=0.
- Wrap: SRC=0FFE, DST=FFFF, LEN=3, RD_LAT=2 → writes to FFFF, 0000, 0001; cpu_rdy low 10 cycles; final DST=0002.
- Reset pulse after the 2nd WRITE of an 8-byte copy → all outputs at reset values in the same cycle; only 2 destination bytes modified; registers read 00.
- Writes to SRC/LEN attempted while cpu_rdy=0 (forced cs/we) → ignored; transfer completes with original parameters.
- RD_LAT=4, LEN=1 → exactly one m_we, asserted 4 cycles after the READ cycle; written byte equals `m_din` sampled in that cycle.
